// File: rtl/idli_sqi_ctrl_m_pkg.sv
// ---------------------------------------------------------------------------
// idli_pkg : shared types and constants for the idli SQI SRAM controller.
// Holds the nibble counter type, the controller state encoding, the SRAM
// command bytes and the phase lengths, plus small nibble-selection helpers.
// ---------------------------------------------------------------------------
package idli_pkg;

    // Nibble position inside a 16-bit word streamed in DATA.
    typedef logic [1:0] ctr_t;

    // Controller phases on the SQI bus.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5
    } sqi_state_t;

    // SRAM command bytes (sent most-significant nibble first).
    localparam logic [7:0] SQI_CMD_RD = 8'h03;
    localparam logic [7:0] SQI_CMD_WR = 8'h02;

    // Phase lengths in nibble cycles.
    localparam int unsigned SQI_CMD_NIBS   = 2;
    localparam int unsigned SQI_ADDR_NIBS  = 6;
    localparam int unsigned SQI_DUMMY_NIBS = 2;

    // Load values for the shared 3-bit phase down-counter (counts to zero).
    localparam logic [2:0] SQI_CMD_LOAD   = 3'(SQI_CMD_NIBS - 1);
    localparam logic [2:0] SQI_ADDR_LOAD  = 3'(SQI_ADDR_NIBS - 1);
    localparam logic [2:0] SQI_DUMMY_LOAD = 3'(SQI_DUMMY_NIBS - 1);

    // Word address to 24-bit SRAM byte address (words are 2 bytes wide).
    function automatic logic [23:0] byte_addr(input logic [15:0] word_addr);
        return {7'b000_0000, word_addr, 1'b0};
    endfunction

    // Pick nibble 'idx' (0 = least significant) out of a 24-bit vector.
    // The phase counter counts down, so idx walks MS nibble to LS nibble.
    function automatic logic [3:0] nib_sel(input logic [23:0] vec,
                                           input logic [2:0]  idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = vec[3:0];
            3'd1:    nib = vec[7:4];
            3'd2:    nib = vec[11:8];
            3'd3:    nib = vec[15:12];
            3'd4:    nib = vec[19:16];
            3'd5:    nib = vec[23:20];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage : idli_pkg

// File: rtl/idli_sqi_ctrl_m_if.sv
// ---------------------------------------------------------------------------
// idli_sqi_ctrl_m_if : bundle of the controller's client-side handshake and
// SRAM-side SQI pins. 'master' is the requesting client plus the SRAM model
// (they drive the controller inputs); 'slave' is the controller view.
// ---------------------------------------------------------------------------
interface idli_sqi_ctrl_m_if;
    import idli_pkg::*;

    // Client request side
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic        stop;
    logic        ack;
    ctr_t        ctr;
    logic        vld;
    logic [3:0]  wdata;
    logic [3:0]  rdata;

    // SRAM pin side
    logic        cs_n;
    logic        sck_en;
    logic        oe;
    logic [3:0]  sio_out;
    logic [3:0]  sio_in;

    modport master (
        output req, wr, addr, stop, wdata, sio_in,
        input  ack, ctr, vld, rdata, cs_n, sck_en, oe, sio_out
    );

    modport slave (
        input  req, wr, addr, stop, wdata, sio_in,
        output ack, ctr, vld, rdata, cs_n, sck_en, oe, sio_out
    );

endinterface : idli_sqi_ctrl_m_if

// File: rtl/idli_sqi_ctrl_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_ctrl_m : SQI (quad SPI) SRAM streaming controller.
//
// A request in IDLE is acknowledged in the same cycle it is seen, then the
// controller sends a 2-nibble command, a 6-nibble byte address, (reads only)
// 2 dummy cycles and streams data nibbles until stopped at a word boundary.
// Words are 4 nibbles; o_sq_ctr marks the nibble position and only ever
// changes stream at ctr==3, so a word is never truncated.
//
// Build option: define IDLI_SQI_REDIRECT_EN to allow a new request to be
// accepted at a DATA word boundary (one GAP cycle with cs_n high, then CMD).
// Without it requests are only taken in IDLE and GAP is never entered.
// ---------------------------------------------------------------------------
module idli_sqi_ctrl_m
    import idli_pkg::*;
(
    input  logic        i_sq_gck,
    input  logic        i_sq_rst,
    input  logic        i_sq_req,
    input  logic        i_sq_wr,
    input  logic [15:0] i_sq_addr,
    input  logic        i_sq_stop,
    output logic        o_sq_ack,
    output ctr_t        o_sq_ctr,
    output logic        o_sq_vld,
    output logic        o_sq_cs_n,
    output logic        o_sq_sck_en,
    output logic        o_sq_oe,
    output logic [3:0]  o_sq_sio,
    input  logic [3:0]  i_sq_sio,
    input  logic [3:0]  i_sq_wdata,
    output logic [3:0]  o_sq_rdata
);

`ifdef IDLI_SQI_REDIRECT_EN
    localparam logic REDIRECT_EN = 1'b1;
`else
    localparam logic REDIRECT_EN = 1'b0;
`endif

    // State and datapath registers
    sqi_state_t  r_state;
    logic [2:0]  r_ph_cnt;
    ctr_t        r_dctr;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [3:0]  r_rdata;

    // Next-state / decoded values
    sqi_state_t  w_state_nxt;
    logic [2:0]  w_ph_cnt_nxt;
    ctr_t        w_dctr_nxt;
    logic        w_wr_nxt;
    logic [15:0] w_addr_nxt;
    logic        w_accept;
    logic        w_cs_n;
    logic        w_oe;
    logic [3:0]  w_sio;
    logic        w_vld;
    ctr_t        w_ctr;
    logic [7:0]  w_cmd;
    logic        w_capture;

    assign w_cmd = r_wr ? SQI_CMD_WR : SQI_CMD_RD;

    // State register plus latched request fields and counters.
    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            r_state  <= ST_IDLE;
            r_ph_cnt <= 3'd0;
            r_dctr   <= 2'd0;
            r_wr     <= 1'b0;
            r_addr   <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_ph_cnt <= w_ph_cnt_nxt;
            r_dctr   <= w_dctr_nxt;
            r_wr     <= w_wr_nxt;
            r_addr   <= w_addr_nxt;
        end
    end

    // Next-state logic: phase sequencing, request acceptance and stop handling.
    always_comb begin
        w_state_nxt  = r_state;
        w_ph_cnt_nxt = r_ph_cnt;
        w_dctr_nxt   = r_dctr;
        w_wr_nxt     = r_wr;
        w_addr_nxt   = r_addr;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_dctr_nxt = 2'd0;
                if (i_sq_req) begin
                    w_accept     = 1'b1;
                    w_wr_nxt     = i_sq_wr;
                    w_addr_nxt   = i_sq_addr;
                    w_ph_cnt_nxt = SQI_CMD_LOAD;
                    w_state_nxt  = ST_CMD;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end

            ST_GAP: begin
                // One cycle with chip select released between streams.
                w_dctr_nxt   = 2'd0;
                w_ph_cnt_nxt = SQI_CMD_LOAD;
                w_state_nxt  = ST_CMD;
            end

            ST_CMD: begin
                if (r_ph_cnt == 3'd0) begin
                    w_ph_cnt_nxt = SQI_ADDR_LOAD;
                    w_state_nxt  = ST_ADDR;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt - 3'd1;
                end
            end

            ST_ADDR: begin
                if (r_ph_cnt != 3'd0) begin
                    w_ph_cnt_nxt = r_ph_cnt - 3'd1;
                end else if (r_wr) begin
                    // Writes go straight to data after the address.
                    w_dctr_nxt  = 2'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_ph_cnt_nxt = SQI_DUMMY_LOAD;
                    w_state_nxt  = ST_DUMMY;
                end
            end

            ST_DUMMY: begin
                if (r_ph_cnt == 3'd0) begin
                    w_dctr_nxt  = 2'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt - 3'd1;
                end
            end

            ST_DATA: begin
                w_dctr_nxt = r_dctr + 2'd1;
                if (r_dctr == 2'd3) begin
                    // Word boundary: a new request beats stop when redirect
                    // is built in; otherwise only stop can end the stream.
                    if (REDIRECT_EN && i_sq_req) begin
                        w_accept    = 1'b1;
                        w_wr_nxt    = i_sq_wr;
                        w_addr_nxt  = i_sq_addr;
                        w_state_nxt = ST_GAP;
                    end else if (i_sq_stop) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pin and stream decode from the registered state.
    always_comb begin
        w_cs_n = 1'b1;
        w_oe   = 1'b0;
        w_sio  = 4'h0;
        w_vld  = 1'b0;
        w_ctr  = 2'd0;

        case (r_state)
            ST_CMD: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                w_sio  = nib_sel({16'h0000, w_cmd}, r_ph_cnt);
            end

            ST_ADDR: begin
                w_cs_n = 1'b0;
                w_oe   = 1'b1;
                w_sio  = nib_sel(byte_addr(r_addr), r_ph_cnt);
            end

            ST_DUMMY: begin
                w_cs_n = 1'b0;
            end

            ST_DATA: begin
                w_cs_n = 1'b0;
                w_vld  = 1'b1;
                w_ctr  = r_dctr;
                if (r_wr) begin
                    // Write data passes straight through to the pins.
                    w_oe  = 1'b1;
                    w_sio = i_sq_wdata;
                end else begin
                    w_oe  = 1'b0;
                end
            end

            default: begin
                w_cs_n = 1'b1;
            end
        endcase
    end

    // Read nibbles are sampled from the last dummy cycle onward, so the
    // nibble shown with ctr==k is the one the SRAM drove the cycle before.
    assign w_capture = (r_state == ST_DUMMY) ||
                       ((r_state == ST_DATA) && !r_wr);

    // Registered read-data nibble.
    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            r_rdata <= 4'h0;
        end else if (w_capture) begin
            r_rdata <= i_sq_sio;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Ack is suppressed while reset is asserted so an aborted cycle never
    // reports acceptance.
    assign o_sq_ack    = w_accept & ~i_sq_rst;
    assign o_sq_ctr    = w_ctr;
    assign o_sq_vld    = w_vld;
    assign o_sq_cs_n   = w_cs_n;
    assign o_sq_sck_en = ~w_cs_n;
    assign o_sq_oe     = w_oe;
    assign o_sq_sio    = w_sio;
    assign o_sq_rdata  = r_rdata;

endmodule : idli_sqi_ctrl_m
